antirebote_multi: RTL and testbench
===================================

# antirebote_multi

Parametrised multi-channel push-button debouncer, the next generation of the single-button debouncer. Each of `N_CH` raw button inputs is synchronised, debounced with separate press and release stability times, normalised to active-high, and decorated with one-cycle press, release and long-press event pulses. It sits between the FPGA button pins and the control FSMs, and replaces per-button debouncer instances.

## Interface
- `N_CH`, 4: number of independent button channels (≥1).
- `COUNT_PRESS`, 50000: consecutive stable cycles required to accept a press (≥1).
- `COUNT_RELEASE`, 501: consecutive stable cycles required to accept a release (≥1).
- `LONG_CYCLES`, 50000000: cycles `boton_out` must stay high before `long_pulse` fires (≥1).
- `ACTIVE_LOW`, 1: 1 means the raw pin reads 0 when pressed; 0 means the raw pin reads 1 when pressed.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `boton_in`  in  N_CH  raw button pins, asynchronous to `clk`.
- `boton_out`  out  N_CH  debounced level, 1 = pressed, regardless of `ACTIVE_LOW`.
- `press_pulse`  out  N_CH  one-cycle pulse when `boton_out[i]` rises.
- `release_pulse`  out  N_CH  one-cycle pulse when `boton_out[i]` falls.
- `long_pulse`  out  N_CH  one-cycle pulse when a press has lasted `LONG_CYCLES`.

## Operation
- Channels are fully independent, with no shared counters. The behaviour below applies per channel `i`.
- Synchroniser: two flops, `s1` then `s2`. On reset both load the inactive pin level, which is `ACTIVE_LOW`.
- Normalised level: `act = s2 ^ ACTIVE_LOW`.
- Threshold selection: `T = COUNT_PRESS` while `boton_out` is 0, and `T = COUNT_RELEASE` while `boton_out` is 1.
- Stability counter, width `$clog2(max(COUNT_PRESS, COUNT_RELEASE)+1)`. Updated every edge:
  - `act == boton_out`: counter ← 0.
  - `act != boton_out` and counter < T-1: counter ← counter+1.
  - `act != boton_out` and counter == T-1: `boton_out` ← `act`, counter ← 0. On that same edge, `press_pulse` ← 1 if `act` is 1, otherwise `release_pulse` ← 1.
- Any single matching cycle clears the counter, so a glitch restarts the qualification.
- `press_pulse` and `release_pulse` are registered and are high only on the cycle after the edge where `boton_out` changed. They are 0 otherwise, and never both high at once.
- Hold counter, width `$clog2(LONG_CYCLES+1)`:
  - Cleared while `boton_out` is 0.
  - Increments each cycle while `boton_out` is 1, saturating at `LONG_CYCLES`.
  - `long_pulse` ← 1 on the edge where the counter goes from `LONG_CYCLES-1` to `LONG_CYCLES`.
  - At most one `long_pulse` per press. A new press re-arms it.
- Counter arithmetic is unsigned. The counters never wrap: the stability counter is bounded by T-1 and the hold counter saturates.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `boton_out`, `press_pulse`, `release_pulse` and `long_pulse` are all 0.
  - All counters are 0; the synchronisers hold the inactive level.
- Reset asserted mid-qualification or mid-hold discards all progress. After `rst` falls, an already-pressed button needs a full `COUNT_PRESS` qualification again.
- Latency: let edge 0 be the first edge at which `s1` captures the new level, with the pin stable from then on.
  - `boton_out` changes at edge T+1.
  - The matching pulse is visible during the cycle that follows edge T+1.
- `long_pulse` is high in the cycle after edge (LONG_CYCLES) counted from the `boton_out` rise edge, which is counted as edge 0.
- Release during long-press qualification clears the hold counter on the edge that `boton_out` falls, and no `long_pulse` is produced.
- If a release is accepted on the same edge that the hold counter would reach `LONG_CYCLES`, the release wins and there is no `long_pulse`.
- Simultaneous events on different channels are independent and may pulse in the same cycle.

## Test plan
All scenarios use `N_CH`=2, `COUNT_PRESS`=8, `COUNT_RELEASE`=3, `LONG_CYCLES`=20, `ACTIVE_LOW`=1.

- **Reset:** assert `rst` with `boton_in`=2'b00 (both pressed).
  - Required: all outputs 0 throughout reset.
  - After release of `rst`: `boton_out[0]` rises exactly 10 edges later, and `press_pulse[0]` is high for 1 cycle.
- **Clean press/release, ch0:** drive `boton_in[0]` to 0 at edge 0, hold 40 cycles, then drive it to 1.
  - Required: `boton_out[0]` rises at edge 9, with `press_pulse` 1 cycle.
  - Required: `long_pulse[0]` fires 20 edges after the rise.
  - Required: `boton_out[0]` falls 4 edges after the pin release, with `release_pulse` 1 cycle.
- **Bounce:** drive `boton_in[0]` low for 7 cycles, high 1 cycle, then low.
  - Required: no press accepted until 8 consecutive low samples.
  - Required: `boton_out[0]` rises at edge 9 counted from the final low capture.
- **Short press:** press accepted, then pin released after `boton_out` has been high for 10 cycles.
  - Required: no `long_pulse`.
  - Required: `release_pulse` after 3 stable high samples.
  - Required: a second press re-arms the long-press detection.
- **Channel independence:** ch1 bounces continuously while ch0 performs a clean press.
  - Required: ch0 timing is unchanged; ch1 `boton_out` stays 0 with no pulses.
- **Async reset mid-hold:** assert `rst` at hold count 15.
  - Required: outputs go to 0 immediately.
  - Required: no `long_pulse`, and no `release_pulse` fires on reset.

Source files
------------

// File: rtl/antirebote_multi.sv
// antirebote_multi: per-channel push-button debouncer with press/release/long-press event pulses.
// Latency: level change accepted T+1 edges after the first synchroniser capture; pulses one cycle later.
// Backpressure: none; free-running, every channel independent and updated every clock.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   boton_in      raw button pins (async to clk), polarity set by ACTIVE_LOW
//   boton_out     debounced level, 1 = pressed
//   press_pulse   one-cycle pulse after boton_out rises
//   release_pulse one-cycle pulse after boton_out falls
//   long_pulse    one-cycle pulse once a press has lasted LONG_CYCLES
module antirebote_multi #(
  parameter int N_CH          = 4,
  parameter int COUNT_PRESS   = 50000,
  parameter int COUNT_RELEASE = 501,
  parameter int LONG_CYCLES   = 50000000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] boton_in,
  output logic [N_CH-1:0] boton_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  localparam int CMAX = (COUNT_PRESS > COUNT_RELEASE) ? COUNT_PRESS : COUNT_RELEASE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int HW   = $clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] PRESS_LAST = CW'(COUNT_PRESS - 1);
  localparam logic [CW-1:0] REL_LAST   = CW'(COUNT_RELEASE - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_ARM   = HW'(LONG_CYCLES - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          s1_q, s1_d, s2_q, s2_d;
    logic          out_q, out_d;
    logic          pp_q, pp_d, rp_q, rp_d, lp_q, lp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          act;
    logic          accept;
    logic [CW-1:0] last;

    always_comb begin
      s1_d   = boton_in[i];
      s2_d   = s1_q;
      act    = s2_q ^ ACTIVE_LOW;
      // Threshold depends on which transition is being qualified.
      last   = out_q ? REL_LAST : PRESS_LAST;
      accept = 1'b0;
      out_d  = out_q;
      cnt_d  = '0;
      pp_d   = 1'b0;
      rp_d   = 1'b0;
      // Any matching sample leaves cnt_d at 0, restarting qualification.
      if (act != out_q) begin
        if (cnt_q == last) begin
          accept = 1'b1;
          out_d  = act;
          pp_d   = act;
          rp_d   = ~act;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      // Hold counter runs only while pressed; an accepted release on this
      // edge clears it and suppresses a coincident long-press pulse.
      hold_d = '0;
      lp_d   = 1'b0;
      if (out_q && !accept) begin
        hold_d = (hold_q != HOLD_MAX) ? hold_q + HW'(1) : hold_q;
        lp_d   = (hold_q == HOLD_ARM);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q   <= ACTIVE_LOW;
        s2_q   <= ACTIVE_LOW;
        out_q  <= 1'b0;
        cnt_q  <= '0;
        hold_q <= '0;
        pp_q   <= 1'b0;
        rp_q   <= 1'b0;
        lp_q   <= 1'b0;
      end else begin
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        out_q  <= out_d;
        cnt_q  <= cnt_d;
        hold_q <= hold_d;
        pp_q   <= pp_d;
        rp_q   <= rp_d;
        lp_q   <= lp_d;
      end
    end

    assign boton_out[i]     = out_q;
    assign press_pulse[i]   = pp_q;
    assign release_pulse[i] = rp_q;
    assign long_pulse[i]    = lp_q;
  end

endmodule

// File: tb/tb_antirebote_multi.sv
`timescale 1ns/1ps
module tb_antirebote_multi;
  localparam int N  = 2;
  localparam int CP = 8;
  localparam int CR = 3;
  localparam int L  = 20;
  localparam bit AL = 1'b1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] boton_in = '1;
  logic [N-1:0] boton_out, press_pulse, release_pulse, long_pulse;

  int vectors = 0;
  int errors  = 0;

  antirebote_multi #(
    .N_CH(N), .COUNT_PRESS(CP), .COUNT_RELEASE(CR), .LONG_CYCLES(L), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst(rst), .boton_in(boton_in), .boton_out(boton_out),
    .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural model: pins pass through a two-sample delay, a level is
  // accepted after a run of T consecutive disagreeing samples, and the
  // long-press fires when the edge count since the rise reaches L.
  logic [N-1:0] m_s1, m_s2, m_out, m_pp, m_rp, m_lp;
  int           m_run  [N];
  longint       m_rise [N];
  longint       cyc = 0;

  task automatic check(input string name, input logic [N-1:0] got, input logic [N-1:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, exp);
    end
  endtask

  task automatic model_step();
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (rst) begin
        m_s1[c] = AL; m_s2[c] = AL; m_out[c] = 1'b0;
        m_pp[c] = 1'b0; m_rp[c] = 1'b0; m_lp[c] = 1'b0;
        m_run[c] = 0;
      end else begin
        bit act;
        bit was_high;
        bit fell;
        int need;
        act      = m_s2[c] ^ AL;
        was_high = m_out[c];
        fell     = 1'b0;
        need     = was_high ? CR : CP;
        m_pp[c] = 1'b0; m_rp[c] = 1'b0; m_lp[c] = 1'b0;
        if (act == m_out[c]) m_run[c] = 0;
        else begin
          m_run[c]++;
          if (m_run[c] == need) begin
            m_out[c] = act;
            m_run[c] = 0;
            if (act) begin m_pp[c] = 1'b1; m_rise[c] = cyc; end
            else begin m_rp[c] = 1'b1; fell = 1'b1; end
          end
        end
        if (was_high && !fell && (cyc - m_rise[c] == L)) m_lp[c] = 1'b1;
        m_s2[c] = m_s1[c];
        m_s1[c] = boton_in[c];
      end
    end
  endtask

  // Every-cycle comparison against the model, 1ns after the edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check("model_out", boton_out,     m_out);
      check("model_pp",  press_pulse,   m_pp);
      check("model_rp",  release_pulse, m_rp);
      check("model_lp",  long_pulse,    m_lp);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog");
  end

  // Inputs change 3ns after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  int ch1_left;
  int seg [N];

  initial begin
    // Reset with both buttons pressed.
    rst = 1'b1;
    boton_in = 2'b00;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      check("rst_out", boton_out, 2'b00);
      check("rst_pulses", press_pulse | release_pulse | long_pulse, 2'b00);
      tick(1);
    end
    rst = 1'b0;
    tick(9);  check("rst_rise_early", boton_out, 2'b00);
    tick(1);  check("rst_rise", boton_out, 2'b11); check("rst_pp", press_pulse, 2'b11);
    tick(1);  check("rst_pp_clear", press_pulse, 2'b00);
    tick(40);
    boton_in = 2'b11;
    tick(12);

    // Clean press/release on ch0.
    boton_in = 2'b10;
    tick(9);  check("clean_early", boton_out, 2'b00);
    tick(1);  check("clean_rise", boton_out, 2'b01); check("clean_pp", press_pulse, 2'b01);
    tick(1);  check("clean_pp_clear", press_pulse, 2'b00);
    tick(18); check("clean_lp_early", long_pulse, 2'b00);
    tick(1);  check("clean_lp", long_pulse, 2'b01);
    tick(1);  check("clean_lp_clear", long_pulse, 2'b00);
    tick(9);
    boton_in = 2'b11;
    tick(4);  check("clean_fall_early", boton_out, 2'b01);
    tick(1);  check("clean_fall", boton_out, 2'b00); check("clean_rp", release_pulse, 2'b01);
    tick(1);  check("clean_rp_clear", release_pulse, 2'b00);
    tick(5);

    // Bounce: 7 low, 1 high, then low.
    boton_in = 2'b10;
    tick(7);  boton_in = 2'b11;
    tick(1);  boton_in = 2'b10;
    tick(9);  check("bounce_early", boton_out, 2'b00);
    tick(1);  check("bounce_rise", boton_out, 2'b01); check("bounce_pp", press_pulse, 2'b01);
    boton_in = 2'b11;
    tick(10);

    // Short press: 10 cycles high, no long pulse, then a re-armed press.
    boton_in = 2'b10;
    tick(10); check("short_rise", boton_out, 2'b01);
    tick(9);  boton_in = 2'b11;
    tick(4);  check("short_fall_early", boton_out, 2'b01);
    tick(1);  check("short_fall", boton_out, 2'b00); check("short_rp", release_pulse, 2'b01);
    for (int k = 0; k < 10; k++) begin
      tick(1); check("short_no_lp", long_pulse, 2'b00);
    end
    boton_in = 2'b10;
    tick(10); check("rearm_rise", boton_out, 2'b01);
    tick(20); check("rearm_lp", long_pulse, 2'b01);
    boton_in = 2'b11;
    tick(10);

    // Channel independence: ch1 bounces with runs shorter than CP.
    boton_in[0] = 1'b0;
    ch1_left = $urandom_range(1, 6);
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      check("indep_ch1_quiet", (boton_out | press_pulse | release_pulse | long_pulse) & 2'b10, 2'b00);
      if (k == 9)  check("indep_early", boton_out & 2'b01, 2'b00);
      if (k == 10) begin
        check("indep_rise", boton_out & 2'b01, 2'b01);
        check("indep_pp", press_pulse & 2'b01, 2'b01);
      end
      ch1_left--;
      if (ch1_left == 0) begin
        boton_in[1] = ~boton_in[1];
        ch1_left = $urandom_range(1, 6);
      end
    end
    boton_in = 2'b11;
    tick(12);

    // Async reset when the hold count is 15.
    boton_in = 2'b10;
    tick(10); check("hold_rise", boton_out, 2'b01);
    tick(15);
    rst = 1'b1;
    #1;
    check("rst_immediate_out", boton_out, 2'b00);
    check("rst_immediate_pulses", press_pulse | release_pulse | long_pulse, 2'b00);
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      tick(1);
      check("hold_rst_no_rp_lp", release_pulse | long_pulse, 2'b00);
      if (k == 9)  check("hold_requal_early", boton_out, 2'b00);
      if (k == 10) check("hold_requal_rise", boton_out, 2'b01);
    end
    boton_in = 2'b11;
    tick(12);

    // Randomised segments on both channels with occasional resets.
    for (int c = 0; c < N; c++) seg[c] = $urandom_range(1, 12);
    for (int k = 0; k < 3000; k++) begin
      tick(1);
      for (int c = 0; c < N; c++) begin
        seg[c]--;
        if (seg[c] == 0) begin
          boton_in[c] = ~boton_in[c];
          seg[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 35) : $urandom_range(1, 9);
        end
      end
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    rst = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
